// File: rtl/ffd_shift_reg.sv
// ============================================================================
//  Module   : ffd_shift_reg
//  Purpose  : WIDTH-bit storage / shift / rotate register with clock enable,
//             synchronous preset and clear, and a self-timed parallel-to-serial
//             converter that shifts a word out LSB-first with busy/done flags.
//  Ports    : clk    - rising-edge clock
//             clr_n  - asynchronous active-low reset
//             pre    - synchronous preset (q <= PRESET_VAL), ignores ce
//             clr    - synchronous clear  (q <= 0), ignores ce, beats pre
//             ce     - enable for mode operations and serializer steps
//             mode   - operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/SER)
//             d      - parallel data
//             sin    - serial fill bit for shifts and the serializer
//             q      - register contents
//             sout   - serial output, always q[0]
//             busy   - serializer running
//             done   - one-cycle pulse when the serializer finishes
//             zero   - combinational (q == 0)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffd_shift_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             pre,
    input  logic             clr,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_SER  = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (clr || pre) begin
            // Either synchronous override aborts a serializer run without done.
            q_d     = clr ? '0 : PRESET_VAL;
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            // mode and d are ignored while shifting; ce=0 simply pauses.
            if (ce) begin
                q_d   = {sin, q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // The edge that puts d[W-1] on sout ends the run, so the
                    // done cycle is already IDLE and accepts a new command.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end else if (ce) begin
            case (mode)
                c_MODE_HOLD: q_d = q_q;
                c_MODE_LOAD: q_d = d;
                c_MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
                c_MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
                c_MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                c_MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                c_MODE_SER: begin
                    // d[0] is on sout right after this edge; WIDTH-1 more
                    // shifts bring out the remaining bits.
                    q_d     = d;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
                default:     q_d = q_q;   // 111 reserved, behaves as HOLD
            endcase
        end
    end

    assign q    = q_q;
    assign sout = q_q[0];
    assign busy = busy_q;
    assign done = done_q;
    assign zero = (q_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_ffd_shift_reg.sv
// ============================================================================
//  Module   : tb_ffd_shift_reg
//  Purpose  : Directed self-checking bench for ffd_shift_reg (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ffd_shift_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             clr_n;
    logic             pre;
    logic             clr;
    logic             ce;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    ffd_shift_reg #(
        .WIDTH      (WIDTH),
        .PRESET_VAL (8'hFF)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .pre   (pre),
        .clr   (clr),
        .ce    (ce),
        .mode  (mode),
        .d     (d),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] ser_word;
    logic [WIDTH-1:0] op_exp [6];
    logic [2:0]       op_mode [6];
    logic             op_sin [6];

    initial begin
        clr_n = 1'b0; pre = 1'b0; clr = 1'b0; ce = 1'b0;
        mode = 3'b000; d = '0; sin = 1'b0;
        ser_word = 8'hB4;

        // Reset state
        repeat (2) step();
        check("rst_q",    32'(q),    32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_zero", 32'(zero), 32'h1);
        clr_n = 1'b1;

        // 1: asynchronous reset in the middle of a serializer run
        ce = 1'b1; mode = 3'b110; d = 8'hB4;
        step();
        check("t1_ser_busy", 32'(busy), 32'h1);
        check("t1_ser_q",    32'(q),    32'hB4);
        mode = 3'b000;
        repeat (2) step();
        #2 clr_n = 1'b0;
        #1;
        check("t1_async_q",    32'(q),    32'h00);
        check("t1_async_busy", 32'(busy), 32'h0);
        check("t1_async_done", 32'(done), 32'h0);
        #2 clr_n = 1'b1;
        step();
        check("t1_rel_q",    32'(q),    32'h00);
        check("t1_rel_busy", 32'(busy), 32'h0);

        // 2: load, enable gating, clear
        ce = 1'b1; mode = 3'b001; d = 8'hA5;
        step();
        check("t2_load", 32'(q), 32'hA5);
        ce = 1'b0; d = 8'h3C;
        step();
        check("t2_ce0",  32'(q),    32'hA5);
        check("t2_zero0", 32'(zero), 32'h0);
        clr = 1'b1;
        step();
        check("t2_clr",   32'(q),    32'h00);
        check("t2_zero1", 32'(zero), 32'h1);
        clr = 1'b0;

        // 3: shift / rotate operations, each starting from A5
        op_mode[0] = 3'b010; op_sin[0] = 1'b1; op_exp[0] = 8'h4B;
        op_mode[1] = 3'b011; op_sin[1] = 1'b0; op_exp[1] = 8'h52;
        op_mode[2] = 3'b100; op_sin[2] = 1'b0; op_exp[2] = 8'h4B;
        op_mode[3] = 3'b101; op_sin[3] = 1'b0; op_exp[3] = 8'hD2;
        op_mode[4] = 3'b111; op_sin[4] = 1'b1; op_exp[4] = 8'hA5;
        op_mode[5] = 3'b000; op_sin[5] = 1'b1; op_exp[5] = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            ce = 1'b1; mode = 3'b001; d = 8'hA5; sin = 1'b0;
            step();
            mode = op_mode[i]; sin = op_sin[i]; d = 8'h00;
            step();
            check($sformatf("t3_op%0d", op_mode[i]), 32'(q), 32'(op_exp[i]));
        end

        // 4: preset/clear ignore ce, clear wins, preset beats LOAD
        ce = 1'b0; mode = 3'b000; pre = 1'b1;
        step();
        check("t4_pre", 32'(q), 32'hFF);
        clr = 1'b1;
        step();
        check("t4_pre_clr", 32'(q), 32'h00);
        clr = 1'b0; ce = 1'b1; mode = 3'b001; d = 8'h12;
        step();
        check("t4_pre_load", 32'(q), 32'hFF);
        pre = 1'b0;

        // 5: full serializer run; mode/d changes during SHIFT must be ignored
        ce = 1'b1; mode = 3'b110; d = ser_word; sin = 1'b0;
        step();
        mode = 3'b001; d = 8'hFF;
        for (int i = 0; i < WIDTH; i++) begin
            if (i > 0) step();
            check($sformatf("t5_sout%0d", i), 32'(sout), 32'(ser_word[i]));
            check($sformatf("t5_busy%0d", i), 32'(busy), (i < WIDTH-1) ? 32'h1 : 32'h0);
            check($sformatf("t5_done%0d", i), 32'(done), (i == WIDTH-1) ? 32'h1 : 32'h0);
        end
        check("t5_final_q", 32'(q), 32'h01);
        mode = 3'b000;
        step();
        check("t5_done_pulse", 32'(done), 32'h0);

        // 6a: pause for two cycles after the third shift
        mode = 3'b110; d = ser_word;
        step();
        mode = 3'b000; d = 8'h00;
        for (int i = 1; i <= 3; i++) step();
        check("t6_sout3", 32'(sout), 32'(ser_word[3]));
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("t6_frz_sout%0d", i), 32'(sout), 32'(ser_word[3]));
            check($sformatf("t6_frz_busy%0d", i), 32'(busy), 32'h1);
            check($sformatf("t6_frz_done%0d", i), 32'(done), 32'h0);
        end
        ce = 1'b1;
        for (int i = 4; i < WIDTH; i++) begin
            step();
            check($sformatf("t6_sout%0d", i), 32'(sout), 32'(ser_word[i]));
            check($sformatf("t6_done%0d", i), 32'(done), (i == WIDTH-1) ? 32'h1 : 32'h0);
        end

        // New SER accepted on the done cycle
        mode = 3'b110; d = 8'h5A;
        step();
        check("t6_reser_q",    32'(q),    32'h5A);
        check("t6_reser_busy", 32'(busy), 32'h1);
        mode = 3'b000; d = 8'h00;
        step();
        check("t6_reser_shift", 32'(q), 32'h2D);

        // 6b: clear aborts the serializer with no done
        clr = 1'b1;
        step();
        check("t6_abort_q",    32'(q),    32'h00);
        check("t6_abort_busy", 32'(busy), 32'h0);
        check("t6_abort_done", 32'(done), 32'h0);
        clr = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            step();
            check($sformatf("t6_nodone%0d", i), 32'(done), 32'h0);
        end
        check("t6_idle_q", 32'(q), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
